riscv_mem_responder: RTL



---
 rtl/riscv_mem_pkg.sv | 30 +++
 rtl/riscv_mem_responder_scanner.sv | 82 ++++++++
 rtl/riscv_mem_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory responder and its post-halt scanner.
//   scan_state_t : scanner FSM encoding (IDLE -> SCAN -> DONE)
//   CHK_ROT      : left-rotate amount applied to the checksum before each fold
//   le_word      : assemble a little-endian 32-bit word from four bytes
//   chk_rotate   : checksum rotate helper
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int CHK_ROT            = 1;
    localparam int MEM_BYTES_DEFAULT  = 65536;
    localparam int DUMP_WORDS_DEFAULT = 256;

    // b0 is the byte at the lowest address.
    function automatic logic [31:0] le_word(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [31:0] chk_rotate(input logic [31:0] v);
        return (v << CHK_ROT) | (v >> (32 - CHK_ROT));
    endfunction

endpackage

// File: rtl/riscv_mem_responder_scanner.sv
// Post-run scan engine. After a rising edge on halted it walks words
// 0..DUMP_WORDS-1 (one per clock) and folds them into a rotate-xor checksum.
//   clk, rst       : clock, asynchronous active-high reset
//   halted         : core halt indication (edge detected here)
//   scan_addr      : byte address of the word wanted this cycle
//   scan_data      : that word, returned combinationally by the parent
//   dump_done      : high in DONE only
//   dump_checksum  : checksum in DONE, zero otherwise
//   state          : current FSM state, exported for observation
module mem_dump_scanner
    import riscv_mem_pkg::*;
#(
    parameter int MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int DUMP_WORDS = DUMP_WORDS_DEFAULT,
    localparam int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halted,
    output logic [AW-1:0] scan_addr,
    input  logic [31:0]   scan_data,
    output logic          dump_done,
    output logic [31:0]   dump_checksum,
    output scan_state_t   state
);

    // One extra count of headroom so idx can reach DUMP_WORDS without wrapping.
    localparam int IW = $clog2(DUMP_WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DUMP_WORDS - 1);

    scan_state_t   state_q;
    scan_state_t   state_d;
    logic          halted_q;
    logic          halt_rise;
    logic [IW-1:0] idx;
    logic [31:0]   chk;

    assign halt_rise = halted & ~halted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE is terminal: only rst leaves it, so later halted activity is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (halt_rise) state_d = SCAN;
            SCAN:    if (idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
            idx      <= '0;
            chk      <= '0;
        end else begin
            halted_q <= halted;
            if (state_q == IDLE && halt_rise) begin
                idx <= '0;
                chk <= '0;
            end else if (state_q == SCAN) begin
                chk <= chk_rotate(chk) ^ scan_data;
                idx <= idx + 1'b1;
            end
        end
    end

    // In DONE idx equals DUMP_WORDS and the address may wrap; the read is unused then.
    assign scan_addr     = AW'({idx, 2'b00});
    assign dump_done     = (state_q == DONE);
    assign dump_checksum = (state_q == DONE) ? chk : 32'd0;
    assign state         = state_q;

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the single-cycle core: one byte-addressed,
// little-endian array serving instruction fetch and data access, plus a
// post-halt checksum scan of the low words.
//   clk, rst       : clock, asynchronous active-high reset (array not cleared)
//   inst_addr/inst : fetch address / combinational fetched word
//   mem_addr       : data byte address; lane i targets mem_addr+i
//   mem_data_in    : write bytes, all four lanes written when mem_write_en=1
//   mem_data_out   : combinational read bytes (pre-write data in a write cycle)
//   halted         : core halt indication, starts the scan on its rising edge
//   err_oob        : sticky flag for accesses reaching past the array top
//   dump_done      : scan complete
//   dump_checksum  : scan result (zero until done)
// Every lane address is reduced modulo MEM_BYTES, so accesses near the top wrap to 0.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int DUMP_WORDS = DUMP_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_in [0:3],
    input  logic        mem_write_en,
    output logic [7:0]  mem_data_out [0:3],
    input  logic        halted,
    output logic        err_oob,
    output logic        dump_done,
    output logic [31:0] dump_checksum
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    logic [7:0]    mem [0:MEM_BYTES-1];

    logic [AW-1:0] i_lane [0:3];
    logic [AW-1:0] d_lane [0:3];
    logic [AW-1:0] s_lane [0:3];
    logic [AW-1:0] scan_addr;
    logic [31:0]   scan_data;
    scan_state_t   scan_state;
    logic          inst_oob;
    logic          data_oob;

    // Truncating to AW bits before adding the lane offset gives the modulo wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            i_lane[i] = inst_addr[AW-1:0] + AW'(i);
            d_lane[i] = mem_addr[AW-1:0] + AW'(i);
            s_lane[i] = scan_addr + AW'(i);
        end
    end

    assign inst = le_word(mem[i_lane[0]], mem[i_lane[1]], mem[i_lane[2]], mem[i_lane[3]]);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_out[i] = mem[d_lane[i]];
        end
    end

    // The scan read port is only meaningful while scanning; it reads zero otherwise.
    assign scan_data = (scan_state == SCAN)
                     ? le_word(mem[s_lane[0]], mem[s_lane[1]], mem[s_lane[2]], mem[s_lane[3]])
                     : 32'd0;

    always_ff @(posedge clk) begin
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                mem[d_lane[i]] <= mem_data_in[i];
            end
        end
    end

    // 33-bit sums so addresses near 2^32 cannot overflow past the comparison.
    // Data-side reads stop counting once the core has halted (the bus may idle anywhere).
    assign inst_oob = ({1'b0, inst_addr} + 33'd3) >= MEM_LIMIT;
    assign data_oob = (({1'b0, mem_addr} + 33'd3) >= MEM_LIMIT) && (mem_write_en || !halted);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_oob <= 1'b0;
        end else if (inst_oob || data_oob) begin
            err_oob <= 1'b1;
        end
    end

    mem_dump_scanner #(
        .MEM_BYTES  (MEM_BYTES),
        .DUMP_WORDS (DUMP_WORDS)
    ) u_scanner (
        .clk           (clk),
        .rst           (rst),
        .halted        (halted),
        .scan_addr     (scan_addr),
        .scan_data     (scan_data),
        .dump_done     (dump_done),
        .dump_checksum (dump_checksum),
        .state         (scan_state)
    );

endmodule
